// File: rtl/pattern_gen_if.sv
// Pixel-side bundle for pattern_gen: coordinates and button in, registered colour and mode out.
interface pattern_gen_if #(
  parameter int X_POS_W = 10,
  parameter int Y_POS_W = 10,
  parameter int COLOR_W = 8
);
  logic [X_POS_W-1:0] x_i;
  logic [Y_POS_W-1:0] y_i;
  logic               btn_i;
  logic [COLOR_W-1:0] red_o;
  logic [COLOR_W-1:0] green_o;
  logic [COLOR_W-1:0] blue_o;
  logic [1:0]         mode_o;

  modport master (
    output x_i, y_i, btn_i,
    input  red_o, green_o, blue_o, mode_o
  );

  modport slave (
    input  x_i, y_i, btn_i,
    output red_o, green_o, blue_o, mode_o
  );
endinterface

// File: rtl/pattern_gen.sv
// Four-mode DVI test-pattern source; RGB is registered one clock after x/y, mode steps on frame boundaries.
// Optional PATTERN_GEN_AUTO_CYCLE_EN adds an 8-bit frame counter that auto-advances the mode every 256 frames.
module pattern_gen #(
  parameter int X_POS_W         = 10,
  parameter int Y_POS_W         = 10,
  parameter int COLOR_W         = 8,
  parameter int H_VISIBLE       = 640,
  parameter int V_VISIBLE       = 480,
  parameter int BOX_SIZE        = 32,
  parameter int CHECKER_BIT     = 5,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  pattern_gen_if.slave  bus
);

  localparam int BAR_W = H_VISIBLE / 8;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int XW1   = X_POS_W + 1;
  localparam int YW1   = Y_POS_W + 1;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_BOX      = 2'd3
  } mode_e;

  mode_e               r_mode;
  logic                r_pending;
  logic [1:0]          r_sync;
  logic                r_db_level;
  logic [DB_W-1:0]     r_db_cnt;
  logic [X_POS_W-1:0]  r_box_x;
  logic [Y_POS_W-1:0]  r_box_y;
  logic                r_dx_neg;
  logic                r_dy_neg;
  logic [COLOR_W-1:0]  r_red;
  logic [COLOR_W-1:0]  r_green;
  logic [COLOR_W-1:0]  r_blue;

  logic                w_frame_tick;
  logic                w_visible;
  logic                w_db_hit;
  logic                w_press;
  logic                w_auto_adv;
  logic [2:0]          w_bar;
  logic [XW1-1:0]      w_box_x_end;
  logic [YW1-1:0]      w_box_y_end;
  logic                w_in_box;
  logic [COLOR_W-1:0]  w_red;
  logic [COLOR_W-1:0]  w_green;
  logic [COLOR_W-1:0]  w_blue;

  assign w_frame_tick = (bus.x_i == '0) && (bus.y_i == Y_POS_W'(V_VISIBLE));
  assign w_visible    = (bus.x_i < X_POS_W'(H_VISIBLE)) && (bus.y_i < Y_POS_W'(V_VISIBLE));

  // Debounced level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  assign w_db_hit = (r_sync[1] != r_db_level) && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign w_press  = w_db_hit && r_sync[1];

  assign w_box_x_end = {1'b0, r_box_x} + XW1'(BOX_SIZE);
  assign w_box_y_end = {1'b0, r_box_y} + YW1'(BOX_SIZE);
  assign w_in_box    = ({1'b0, bus.x_i} >= {1'b0, r_box_x}) && ({1'b0, bus.x_i} < w_box_x_end) &&
                       ({1'b0, bus.y_i} >= {1'b0, r_box_y}) && ({1'b0, bus.y_i} < w_box_y_end);

  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (bus.x_i >= X_POS_W'(k * BAR_W)) w_bar = 3'(k);
    end
  end

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    case (r_mode)
      MODE_BARS: begin
        w_red   = {COLOR_W{~w_bar[1]}};
        w_green = {COLOR_W{~w_bar[2]}};
        w_blue  = {COLOR_W{~w_bar[0]}};
      end
      MODE_CHECKER: begin
        w_red   = {COLOR_W{bus.x_i[CHECKER_BIT] ^ bus.y_i[CHECKER_BIT]}};
        w_green = w_red;
        w_blue  = w_red;
      end
      MODE_GRADIENT: begin
        w_red   = bus.x_i[X_POS_W-1 -: COLOR_W];
        w_green = bus.y_i[Y_POS_W-1 -: COLOR_W];
      end
      default: begin
        w_red   = {COLOR_W{w_in_box}};
        w_green = {COLOR_W{w_in_box}};
        w_blue  = w_in_box ? {COLOR_W{1'b1}} : (COLOR_W'(1) << (COLOR_W - 2));
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync     <= '0;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.btn_i};
      if (r_sync[1] == r_db_level) begin
        r_db_cnt <= '0;
      end else if (w_db_hit) begin
        r_db_level <= r_sync[1];
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

`ifdef PATTERN_GEN_AUTO_CYCLE_EN
  logic [7:0] r_frame_cnt;

  assign w_auto_adv = w_frame_tick && (r_frame_cnt == 8'hFF);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_frame_cnt <= 8'd0;
    end else if (w_frame_tick) begin
      r_frame_cnt <= r_pending ? 8'd0 : r_frame_cnt + 8'd1;
    end
  end
`else
  assign w_auto_adv = 1'b0;
`endif

  // A press landing on the tick itself is kept pending for the following frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mode    <= MODE_BARS;
      r_pending <= 1'b0;
    end else if (w_frame_tick) begin
      if (r_pending || w_auto_adv) r_mode <= mode_e'(r_mode + 2'd1);
      r_pending <= w_press;
    end else if (w_press) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_box_x  <= '0;
      r_box_y  <= '0;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
    end else if (w_frame_tick) begin
      if (!r_dx_neg) begin
        if (w_box_x_end == XW1'(H_VISIBLE)) begin
          r_dx_neg <= 1'b1;
          r_box_x  <= r_box_x - X_POS_W'(1);
        end else begin
          r_box_x <= r_box_x + X_POS_W'(1);
        end
      end else if (r_box_x == '0) begin
        r_dx_neg <= 1'b0;
        r_box_x  <= X_POS_W'(1);
      end else begin
        r_box_x <= r_box_x - X_POS_W'(1);
      end

      if (!r_dy_neg) begin
        if (w_box_y_end == YW1'(V_VISIBLE)) begin
          r_dy_neg <= 1'b1;
          r_box_y  <= r_box_y - Y_POS_W'(1);
        end else begin
          r_box_y <= r_box_y + Y_POS_W'(1);
        end
      end else if (r_box_y == '0) begin
        r_dy_neg <= 1'b0;
        r_box_y  <= Y_POS_W'(1);
      end else begin
        r_box_y <= r_box_y - Y_POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !w_visible) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_red   <= w_red;
      r_green <= w_green;
      r_blue  <= w_blue;
    end
  end

  assign bus.red_o   = r_red;
  assign bus.green_o = r_green;
  assign bus.blue_o  = r_blue;
  assign bus.mode_o  = r_mode;

endmodule

// File: tb/tb_pattern_gen.sv
// Randomised scoreboard bench for pattern_gen with a frame-level reference model.
module tb_pattern_gen;

  localparam int HV  = 640;
  localparam int VV  = 480;
  localparam int BOX = 32;
  localparam int DEB = 16;

  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct packed {
    logic [23:0] rgb;
    logic [1:0]  mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_gen_if #(.X_POS_W(10), .Y_POS_W(10), .COLOR_W(8)) bus ();

  pattern_gen #(
    .X_POS_W(10), .Y_POS_W(10), .COLOR_W(8), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .BOX_SIZE(BOX), .CHECKER_BIT(5), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model state
  int m_mode = 0, m_pending = 0, m_ticks = 0, m_fcnt = 0;
  int s1 = 0, s2 = 0, deb = 0, dcnt = 0;
  int bx = 0, by = 0, dx = 1, dy = 1;

  function automatic logic [23:0] pix(input int mode, input int x, input int y,
                                      input int boxx, input int boxy);
    logic [7:0] r8, g8;
    if (x >= HV || y >= VV) return 24'h000000;
    case (mode)
      0: return BAR_RGB[x / (HV / 8)];
      1: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      2: begin
        r8 = 8'(x >> 2);
        g8 = 8'(y >> 2);
        return {r8, g8, 8'h00};
      end
      default: begin
        if (x >= boxx && x < boxx + BOX && y >= boxy && y < boxy + BOX) return 24'hFFFFFF;
        return 24'h000040;
      end
    endcase
  endfunction

  // Reflect off a wall by reversing before stepping when the step would leave the screen.
  task automatic move_axis(inout int pos, inout int dir, input int limit);
    if (pos + dir < 0 || pos + dir + BOX > limit) dir = -dir;
    pos = pos + dir;
  endtask

  task automatic step(input int x, input int y, input bit b, input bit rst, input string tag);
    exp_t e;
    bit   rise, tick, auto_adv;
    @(negedge clk);
    bus.x_i   = 10'(x);
    bus.y_i   = 10'(y);
    bus.btn_i = b;
    rst_n     = rst;
    if (!rst) begin
      e.rgb = 24'h0; e.mode = 2'd0;
      m_mode = 0; m_pending = 0; m_ticks = 0; m_fcnt = 0;
      s1 = 0; s2 = 0; deb = 0; dcnt = 0;
      bx = 0; by = 0; dx = 1; dy = 1;
    end else begin
      e.rgb = pix(m_mode, x, y, bx, by);
      tick = (x == 0 && y == VV);
      rise = 1'b0;
      if (s2 != deb) begin
        dcnt++;
        if (dcnt == DEB) begin
          deb = s2; dcnt = 0; rise = (deb == 1);
        end
      end else begin
        dcnt = 0;
      end
      s2 = s1; s1 = int'(b);
      if (tick) begin
        auto_adv = 1'b0;
`ifdef PATTERN_GEN_AUTO_CYCLE_EN
        m_fcnt = (m_fcnt + 1) % 256;
        auto_adv = (m_fcnt == 0);
        if (m_pending != 0) m_fcnt = 0;
`endif
        if (m_pending != 0 || auto_adv) m_mode = (m_mode + 1) % 4;
        m_pending = int'(rise);
        move_axis(bx, dx, HV);
        move_axis(by, dy, VV);
        m_ticks++;
      end else if (rise) begin
        m_pending = 1;
      end
      e.mode = 2'(m_mode);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic rand_px(input int n, input bit b, input string tag);
    for (int i = 0; i < n; i++)
      step(int'($urandom_range(0, HV - 1)), int'($urandom_range(0, VV - 1)), b, 1'b1, tag);
  endtask

  task automatic frame_tick(input string tag);
    step(0, VV, 1'b0, 1'b1, tag);
  endtask

  task automatic press();
    rand_px(DEB + 2, 1'b1, "press_hold");
    rand_px(DEB + 2, 1'b0, "press_release");
  endtask

  task automatic box_probe(input string tag);
    step(bx + BOX - 1, by, 1'b0, 1'b1, tag);
    step(bx + BOX, by, 1'b0, 1'b1, tag);
    step(bx, by + BOX - 1, 1'b0, 1'b1, tag);
    step(bx, by + BOX, 1'b0, 1'b1, tag);
    if (bx > 0) step(bx - 1, by, 1'b0, 1'b1, tag);
  endtask

  // Monitor: compare every registered output against the queued expectation.
  initial begin
    exp_t  e;
    string t;
    logic [23:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        act = {bus.red_o, bus.green_o, bus.blue_o};
        total++;
        if (act !== e.rgb || bus.mode_o !== e.mode) begin
          bad++;
          $display("FAIL %s: got rgb=%06h mode=%0d, want rgb=%06h mode=%0d",
                   t, act, bus.mode_o, e.rgb, e.mode);
        end
      end
    end
  end

  initial begin
    int btn_lvl;
    int x, y;
    bus.x_i = '0; bus.y_i = '0; bus.btn_i = 1'b0;

    for (int i = 0; i < 3; i++)
      step(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'b0, 1'b0, "reset");
    step(0, 0, 1'b0, 1'b1, "release_white");

    step(79, 10, 1'b0, 1'b1, "bar_79");
    step(80, 10, 1'b0, 1'b1, "bar_80");
    step(400, 10, 1'b0, 1'b1, "bar_400");
    step(639, 10, 1'b0, 1'b1, "bar_639");
    step(640, 10, 1'b0, 1'b1, "bar_blank");
    rand_px(40, 1'b0, "bars_rand");

    press();
    rand_px(10, 1'b0, "pending_no_change");
    frame_tick("tick_to_checker");
    step(32, 0, 1'b0, 1'b1, "chk_32_0");
    step(32, 32, 1'b0, 1'b1, "chk_32_32");
    rand_px(30, 1'b0, "chk_rand");

    press();
    frame_tick("tick_to_gradient");
    step(636, 476, 1'b0, 1'b1, "grad_636_476");
    step(700, 476, 1'b0, 1'b1, "grad_blank");
    rand_px(30, 1'b0, "grad_rand");

    rand_px(DEB - 1, 1'b1, "glitch_hold");
    rand_px(DEB + 4, 1'b0, "glitch_release");
    frame_tick("glitch_tick_no_change");

    press(); press(); press();
    frame_tick("triple_press_tick");
    frame_tick("triple_press_once");
    rand_px(20, 1'b0, "box_rand");

    while (m_ticks < 609) frame_tick("box_run");
    box_probe("box_turn");
    for (int i = 0; i < 30; i++) begin
      x = bx + int'($urandom_range(0, 40)) - 4;
      y = by + int'($urandom_range(0, 40)) - 4;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      step(x, y, 1'b0, 1'b1, "box_near");
    end

    step(100, 50, 1'b0, 1'b0, "midframe_reset");
    step(0, 0, 1'b0, 1'b1, "post_reset_white");
    for (int i = 0; i < 3; i++) begin
      press();
      frame_tick("re_advance");
    end
    box_probe("box_after_reset");

    btn_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) btn_lvl = 1 - btn_lvl;
      if ($urandom_range(0, 49) == 0) begin
        step(0, VV, btn_lvl[0], 1'b1, "rand_tick");
      end else if ($urandom_range(0, 3) == 0) begin
        x = bx + int'($urandom_range(0, 40)) - 4;
        y = by + int'($urandom_range(0, 40)) - 4;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        step(x, y, btn_lvl[0], 1'b1, "rand_box");
      end else begin
        step(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), btn_lvl[0], 1'b1, "rand_px");
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
